pipe_op_receiver: RTL and testbench
===================================

Name: pipe_op_receiver

Overview:
- Receive end of the pipeline-operation stream: accepts 2-bit stage tokens (FETCH, DECODE, EXECUTE, STORE) one per handshake.
- Buffers accepted tokens in a small FIFO for a downstream consumer.
- Checks that tokens arrive in strict FETCH→DECODE→EXECUTE→STORE order, counts completed instructions and sequence errors.
- Sits between the operation issuer and the stage-status logger.

Parameters:
DEPTH, 4, FIFO entries; power of 2, ≥2
CNT_W, 16, width of instr_count and err_count
TS_W, 16, timestamp width (used only with PIPE_OP_TIMESTAMP_EN)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active-low
op_valid  in  1  issuer presents a token
op_code  in  2  token: 0=FETCH 1=DECODE 2=EXECUTE 3=STORE
op_ready  out  1  receiver can accept
deq_valid  out  1  FIFO head valid
deq_code  out  2  FIFO head token
deq_ready  in  1  consumer pops head
level  out  $clog2(DEPTH)+1  FIFO occupancy
expect_code  out  2  next token the checker expects
instr_count  out  CNT_W  completed in-order FETCH..STORE sequences
err_count  out  CNT_W  sequence violations
seq_err  out  1  sticky violation flag
err_clr  in  1  clears seq_err
deq_time  out  TS_W  timestamp of head token (PIPE_OP_TIMESTAMP_EN only)

Behaviour:
- Reset (rst_n=0 at rising edge): level=0, deq_valid=0, deq_code=0, expect_code=0 (FETCH), instr_count=0, err_count=0, seq_err=0, pointers=0, timestamp counter=0. op_ready=0 while rst_n=0.
- Accept: push when op_valid && op_ready. op_ready = rst_n && (level != DEPTH). A pop in the same cycle does not free space for a push when full.
- Pop: when deq_valid && deq_ready. deq_valid = (level != 0). deq_code = mem[rd_ptr]. deq_ready while empty is ignored.
- Latency: a token accepted at edge N is visible on deq_* after edge N. It is at the head in the following cycle when the FIFO was empty.
- Simultaneous push and pop (not full, not empty): level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Checker FSM has four states, EXP_FETCH→EXP_DECODE→EXP_EXECUTE→EXP_STORE→EXP_FETCH. expect_code reflects the state encoding.
- The checker evaluates only accepted tokens.
- Match: advance to the next state. Accepting STORE in EXP_STORE also increments instr_count.
- Mismatch:
  - err_count increments and seq_err is set.
  - Resync: if the token is FETCH, go to EXP_DECODE; otherwise go to EXP_FETCH.
  - Mismatched tokens are still pushed into the FIFO.
- Counters saturate at all-ones and never wrap.
- err_clr=1 clears seq_err at the next edge. A mismatch in the same cycle wins, so seq_err stays 1.
- Reset mid-operation: FIFO contents are discarded and all state returns to reset values on that edge. Any in-flight handshake in that cycle is dropped.

Optional Feature:
- Macro: PIPE_OP_TIMESTAMP_EN.
- Defined:
  - A free-running TS_W-bit cycle counter starts at 0 after reset and wraps.
  - Each pushed entry stores the counter value at the accept edge.
  - deq_time outputs the head entry's timestamp, and 0 when empty.
- Undefined: no timestamp counter or storage, and the deq_time port is absent.

Test Plan:
1. Reset, then push 0,1,2,3 on consecutive cycles with deq_ready=0 → level=4, op_ready=0, instr_count=1, err_count=0, expect_code=0. Then pop 4 times → deq_code 0,1,2,3, level=0, deq_valid=0.
2. Full FIFO, op_valid=1 and deq_ready=1 in the same cycle → pop occurs, no push, level=3. Next cycle the push is accepted and level=4.
3. Push 0,2 → err_count=1, seq_err=1, expect_code=0. Then push 0,1,2,3 → instr_count=1. Assert err_clr → seq_err=0, err_count stays 1.
4. Push 1 (mismatch, expect_code=0) in the same cycle as err_clr=1 → seq_err remains 1. Then push 0 → expect_code=1.
5. Stream 10 full sequences with deq_ready=1 → level stays ≤1, instr_count=10, pointer wrap is correct, and the data order is preserved.
6. Push 0,1, then rst_n=0 for one cycle → level=0, expect_code=0, counters=0. With PIPE_OP_TIMESTAMP_EN, tokens pushed at cycles 3 and 5 after reset show deq_time=3 and then 5.

Source files
------------

// File: rtl/pipe_op_receiver.sv
// Receive end of the pipeline-operation stream: token FIFO plus in-order stage checker.
// Optional macro PIPE_OP_TIMESTAMP_EN adds per-entry accept timestamps on deq_time.
module pipe_op_receiver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TS_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_valid,
    input  logic [1:0]                 op_code,
    output logic                       op_ready,
    output logic                       deq_valid,
    output logic [1:0]                 deq_code,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [1:0]                 expect_code,
    output logic [CNT_W-1:0]           instr_count,
    output logic [CNT_W-1:0]           err_count,
    output logic                       seq_err,
    input  logic                       err_clr
`ifdef PIPE_OP_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]            deq_time
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        EXP_FETCH   = 2'd0,
        EXP_DECODE  = 2'd1,
        EXP_EXECUTE = 2'd2,
        EXP_STORE   = 2'd3
    } state_t;

    logic [1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             seq_err_q, seq_err_d;

    logic push;
    logic pop;

    // Full blocks the push even when a pop happens in the same cycle.
    assign op_ready  = rst_n && (level_q != LVL_W'(DEPTH));
    assign deq_valid = (level_q != '0);
    assign push      = op_valid && op_ready;
    assign pop       = deq_valid && deq_ready;

    assign deq_code    = deq_valid ? mem_q[rd_ptr_q] : 2'b00;
    assign level       = level_q;
    assign expect_code = state_q;
    assign instr_count = instr_q;
    assign err_count   = err_q;
    assign seq_err     = seq_err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Checker: only accepted tokens advance it; mismatches resync on FETCH.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        err_d     = err_q;
        seq_err_d = seq_err_q;
        if (err_clr) begin
            seq_err_d = 1'b0;
        end
        if (push) begin
            if (op_code == 2'(state_q)) begin
                case (state_q)
                    EXP_FETCH:   state_d = EXP_DECODE;
                    EXP_DECODE:  state_d = EXP_EXECUTE;
                    EXP_EXECUTE: state_d = EXP_STORE;
                    default: begin
                        state_d = EXP_FETCH;
                        if (instr_q != '1) begin
                            instr_d = instr_q + CNT_W'(1);
                        end
                    end
                endcase
            end else begin
                if (err_q != '1) begin
                    err_d = err_q + CNT_W'(1);
                end
                seq_err_d = 1'b1;
                state_d   = (op_code == 2'd0) ? EXP_DECODE : EXP_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= EXP_FETCH;
            instr_q   <= '0;
            err_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            seq_err_q <= seq_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= op_code;
        end
    end

`ifdef PIPE_OP_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] ts_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem_q[wr_ptr_q] <= ts_q;
        end
    end

    assign deq_time = deq_valid ? ts_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_pipe_op_receiver.sv
// Directed bench for pipe_op_receiver with a token scoreboard and reference checker model.
module tb_pipe_op_receiver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int TS_W  = 16;

    logic             clk;
    logic             rst_n;
    logic             op_valid;
    logic [1:0]       op_code;
    logic             op_ready;
    logic             deq_valid;
    logic [1:0]       deq_code;
    logic             deq_ready;
    logic [2:0]       level;
    logic [1:0]       expect_code;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] err_count;
    logic             seq_err;
    logic             err_clr;
`ifdef PIPE_OP_TIMESTAMP_EN
    logic [TS_W-1:0]  deq_time;
`endif

    pipe_op_receiver #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .TS_W (TS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_ready   (op_ready),
        .deq_valid  (deq_valid),
        .deq_code   (deq_code),
        .deq_ready  (deq_ready),
        .level      (level),
        .expect_code(expect_code),
        .instr_count(instr_count),
        .err_count  (err_count),
        .seq_err    (seq_err),
        .err_clr    (err_clr)
`ifdef PIPE_OP_TIMESTAMP_EN
        ,
        .deq_time   (deq_time)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    logic [1:0]      sb_q [$];
    logic [TS_W-1:0] ts_sb_q [$];
    logic [1:0]      m_exp;
    int unsigned     m_icnt;
    int unsigned     m_ecnt;
    logic            m_serr;
    logic [TS_W-1:0] m_ts;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Checks every output before the edge, then advances the model across it.
    task automatic tick();
        logic acc;
        logic pp;
        @(negedge clk);
        check("op_ready", 32'(op_ready), 32'(rst_n && (sb_q.size() != DEPTH)));
        check("level", 32'(level), 32'(sb_q.size()));
        check("deq_valid", 32'(deq_valid), 32'(sb_q.size() != 0));
        check("deq_code", 32'(deq_code), (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'd0);
        check("expect_code", 32'(expect_code), 32'(m_exp));
        check("instr_count", 32'(instr_count), m_icnt);
        check("err_count", 32'(err_count), m_ecnt);
        check("seq_err", 32'(seq_err), 32'(m_serr));
`ifdef PIPE_OP_TIMESTAMP_EN
        check("deq_time", 32'(deq_time), (ts_sb_q.size() != 0) ? 32'(ts_sb_q[0]) : 32'd0);
`endif
        if (!rst_n) begin
            sb_q.delete();
            ts_sb_q.delete();
            m_exp  = 2'd0;
            m_icnt = 0;
            m_ecnt = 0;
            m_serr = 1'b0;
            m_ts   = '0;
        end else begin
            acc = op_valid && (sb_q.size() != DEPTH);
            pp  = deq_ready && (sb_q.size() != 0);
            if (pp) begin
                void'(sb_q.pop_front());
                void'(ts_sb_q.pop_front());
            end
            if (err_clr) m_serr = 1'b0;
            if (acc) begin
                sb_q.push_back(op_code);
                ts_sb_q.push_back(m_ts);
                if (op_code == m_exp) begin
                    if (m_exp == 2'd3 && m_icnt != 32'hFFFF) m_icnt++;
                    m_exp = m_exp + 2'd1;
                end else begin
                    if (m_ecnt != 32'hFFFF) m_ecnt++;
                    m_serr = 1'b1;
                    m_exp  = (op_code == 2'd0) ? 2'd1 : 2'd0;
                end
            end
            m_ts = m_ts + TS_W'(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_tok(input logic [1:0] c);
        op_valid = 1'b1;
        op_code  = c;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_expect", 32'(expect_code), 32'd0);
        check("rst_icnt", 32'(instr_count), 32'd0);
        check("rst_ecnt", 32'(err_count), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_code   = 2'd0;
        deq_ready = 1'b0;
        err_clr   = 1'b0;
        m_exp     = 2'd0;
        m_icnt    = 0;
        m_ecnt    = 0;
        m_serr    = 1'b0;
        m_ts      = '0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: fill with one full sequence, then drain in order
        for (int i = 0; i < 4; i++) push_tok(2'(i));
        check("t1_level", 32'(level), 32'd4);
        check("t1_op_ready", 32'(op_ready), 32'd0);
        check("t1_icnt", 32'(instr_count), 32'd1);
        check("t1_ecnt", 32'(err_count), 32'd0);
        check("t1_expect", 32'(expect_code), 32'd0);
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        deq_ready = 1'b0;
        check("t1_drain_level", 32'(level), 32'd0);
        check("t1_drain_valid", 32'(deq_valid), 32'd0);

        // 2: full FIFO with push and pop in the same cycle
        for (int i = 0; i < 4; i++) push_tok(2'(i));
        op_valid  = 1'b1;
        op_code   = 2'd0;
        deq_ready = 1'b1;
        tick();
        check("t2_level_pop", 32'(level), 32'd3);
        deq_ready = 1'b0;
        tick();
        op_valid = 1'b0;
        check("t2_level_push", 32'(level), 32'd4);
        do_reset();

        // 3: mismatch, recovery, then err_clr
        deq_ready = 1'b1;
        push_tok(2'd0);
        push_tok(2'd2);
        check("t3_ecnt", 32'(err_count), 32'd1);
        check("t3_serr", 32'(seq_err), 32'd1);
        check("t3_expect", 32'(expect_code), 32'd0);
        for (int i = 0; i < 4; i++) push_tok(2'(i));
        check("t3_icnt", 32'(instr_count), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_serr_clr", 32'(seq_err), 32'd0);
        check("t3_ecnt_hold", 32'(err_count), 32'd1);

        // 4: mismatch wins over err_clr
        err_clr = 1'b1;
        push_tok(2'd1);
        err_clr = 1'b0;
        check("t4_serr", 32'(seq_err), 32'd1);
        check("t4_expect", 32'(expect_code), 32'd0);
        push_tok(2'd0);
        check("t4_expect_dec", 32'(expect_code), 32'd1);
        tick();

        // 5: streaming with pointer wrap
        do_reset();
        deq_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_tok(2'(i % 4));
            check("t5_level_le1", 32'(level <= 3'd1), 32'd1);
        end
        tick();
        check("t5_icnt", 32'(instr_count), 32'd10);
        check("t5_empty", 32'(deq_valid), 32'd0);

        // 6: reset mid-operation drops contents and in-flight push
        do_reset();
        deq_ready = 1'b0;
        push_tok(2'd0);
        push_tok(2'd1);
        rst_n    = 1'b0;
        op_valid = 1'b1;
        op_code  = 2'd2;
        tick();
        rst_n    = 1'b1;
        op_valid = 1'b0;
        check("t6_level", 32'(level), 32'd0);
        check("t6_expect", 32'(expect_code), 32'd0);
        check("t6_icnt", 32'(instr_count), 32'd0);
        check("t6_ecnt", 32'(err_count), 32'd0);
        tick();
        tick();
        push_tok(2'd0);
        tick();
        push_tok(2'd1);
        deq_ready = 1'b1;
        tick();
        tick();
        tick();

        // mixed traffic
        for (int i = 0; i < 80; i++) begin
            op_valid  = ($urandom_range(0, 3) != 0);
            op_code   = 2'($urandom_range(0, 3));
            deq_ready = ($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 7) == 0);
            tick();
        end
        op_valid = 1'b0;
        err_clr  = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
